// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predict unit: 2-bit counter type,
// its state constants and the saturating counter update.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    localparam int unsigned PC_INC = 4;

    // Saturating step: never wraps strongly-taken to strongly-not-taken or back.
    function automatic ctr_t ctr_next(ctr_t ctr, logic taken);
        ctr_t nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) nxt = 2'(ctr + 2'd1);
        end else begin
            if (ctr != CTR_SNT) nxt = 2'(ctr - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/resolve bus between the pipeline (master) and the branch predict unit (slave).
interface branch_predict_unit_if #(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned CNT_W = 16
);
    logic [PC_W-1:0]  fetch_pc;
    logic             halt;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic [PC_W-1:0]  next_pc;

    logic             res_valid;
    logic [PC_W-1:0]  res_pc;
    logic             res_is_jump;
    logic             res_taken;
    logic [PC_W-1:0]  res_target;
    logic             res_pred_taken;
    logic [PC_W-1:0]  res_pred_target;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;

    logic [CNT_W-1:0] n_branches;
    logic [CNT_W-1:0] n_mispredicts;

    modport master (
        output fetch_pc, halt,
        output res_valid, res_pc, res_is_jump, res_taken, res_target,
        output res_pred_taken, res_pred_target,
        input  pred_taken, pred_target, next_pc,
        input  mispredict, redirect_pc,
        input  n_branches, n_mispredicts
    );

    modport slave (
        input  fetch_pc, halt,
        input  res_valid, res_pc, res_is_jump, res_taken, res_target,
        input  res_pred_taken, res_pred_target,
        output pred_taken, pred_target, next_pc,
        output mispredict, redirect_pc,
        output n_branches, n_mispredicts
    );

endinterface

// File: rtl/bp_table.sv
// Direct-mapped BTB with per-entry 2-bit counters: combinational read/tag compare,
// clocked write with counter update, async-reset clear.
module bp_table
    import bp_pkg::*;
#(
    parameter int unsigned PC_W    = 9,
    parameter int unsigned ENTRIES = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [$clog2(ENTRIES)-1:0]            rd_idx_i,
    input  logic [PC_W-$clog2(ENTRIES)-3:0]       rd_tag_i,
    output logic                                  rd_hit_o,
    output logic [PC_W-1:0]                       rd_target_o,
    output ctr_t                                  rd_ctr_o,
    input  logic                                  wr_en_i,
    input  logic [$clog2(ENTRIES)-1:0]            wr_idx_i,
    input  logic [PC_W-$clog2(ENTRIES)-3:0]       wr_tag_i,
    input  logic                                  wr_taken_i,
    input  logic                                  wr_jump_i,
    input  logic [PC_W-1:0]                       wr_target_i
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    ctr_t             ctr_q    [ENTRIES];

    logic wr_hit;
    ctr_t ctr_d;

    // Read side sees pre-update contents; there is no write-to-read bypass.
    always_comb begin
        rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
        rd_target_o = rd_hit_o ? target_q[rd_idx_i] : '0;
        rd_ctr_o    = ctr_q[rd_idx_i];
    end

    // A miss (re)allocates with a weak counter in the resolved direction.
    always_comb begin
        wr_hit = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);
        ctr_d  = ctr_q[wr_idx_i];
        if (!wr_hit) begin
            ctr_d = wr_taken_i ? CTR_WT : CTR_WNT;
        end else if (wr_jump_i) begin
            ctr_d = CTR_ST;
        end else begin
            ctr_d = ctr_next(ctr_q[wr_idx_i], wr_taken_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (wr_en_i) begin
            valid_q[wr_idx_i]  <= 1'b1;
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
            ctr_q[wr_idx_i]    <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: BTB/counter lookup at fetch, outcome compare at EX,
// next-PC selection and saturating performance counters.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int unsigned PC_W    = 9,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_predict_unit_if.slave  bp_if
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = PC_W - IDX_W - 2;

    if (PC_W < IDX_W + 3) begin : g_pc_w_check
        $error("branch_predict_unit: PC_W too small for ENTRIES");
    end

    logic             taken_a;
    logic             tbl_hit;
    logic [PC_W-1:0]  tbl_target;
    ctr_t             tbl_ctr;
    logic             pred_taken_c;
    logic [PC_W-1:0]  pred_target_c;
    logic             mispredict_c;
    logic [PC_W-1:0]  redirect_c;
    logic [PC_W-1:0]  next_pc_c;
    logic [CNT_W-1:0] n_br_q, n_br_d;
    logic [CNT_W-1:0] n_mp_q, n_mp_d;

    bp_table #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_idx_i    (bp_if.fetch_pc[IDX_W+1:2]),
        .rd_tag_i    (bp_if.fetch_pc[PC_W-1:IDX_W+2]),
        .rd_hit_o    (tbl_hit),
        .rd_target_o (tbl_target),
        .rd_ctr_o    (tbl_ctr),
        .wr_en_i     (bp_if.res_valid),
        .wr_idx_i    (bp_if.res_pc[IDX_W+1:2]),
        .wr_tag_i    (TAG_W'(bp_if.res_pc[PC_W-1:IDX_W+2])),
        .wr_taken_i  (taken_a),
        .wr_jump_i   (bp_if.res_is_jump),
        .wr_target_i (bp_if.res_target)
    );

    // Fetch prediction, EX resolution and next-PC priority select.
    always_comb begin
        taken_a       = bp_if.res_is_jump | bp_if.res_taken;
        pred_taken_c  = tbl_hit && tbl_ctr[1] && !bp_if.halt;
        pred_target_c = tbl_hit ? tbl_target : '0;
        mispredict_c  = 1'b0;
        redirect_c    = '0;
        if (bp_if.res_valid) begin
            mispredict_c = (taken_a != bp_if.res_pred_taken) ||
                           (taken_a && (bp_if.res_target != bp_if.res_pred_target));
            redirect_c   = taken_a ? bp_if.res_target
                                   : PC_W'(bp_if.res_pc + PC_W'(PC_INC));
        end
        if (mispredict_c) begin
            next_pc_c = redirect_c;
        end else if (bp_if.halt) begin
            next_pc_c = bp_if.fetch_pc;
        end else if (pred_taken_c) begin
            next_pc_c = pred_target_c;
        end else begin
            next_pc_c = PC_W'(bp_if.fetch_pc + PC_W'(PC_INC));
        end
    end

    // Stat counters stick at all-ones instead of wrapping.
    always_comb begin
        n_br_d = n_br_q;
        n_mp_d = n_mp_q;
        if (bp_if.res_valid && (n_br_q != '1)) n_br_d = CNT_W'(n_br_q + CNT_W'(1));
        if (mispredict_c && (n_mp_q != '1))    n_mp_d = CNT_W'(n_mp_q + CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_br_q <= '0;
            n_mp_q <= '0;
        end else begin
            n_br_q <= n_br_d;
            n_mp_q <= n_mp_d;
        end
    end

    assign bp_if.pred_taken    = pred_taken_c;
    assign bp_if.pred_target   = pred_target_c;
    assign bp_if.next_pc       = next_pc_c;
    assign bp_if.mispredict    = mispredict_c;
    assign bp_if.redirect_pc   = redirect_c;
    assign bp_if.n_branches    = n_br_q;
    assign bp_if.n_mispredicts = n_mp_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus random
// traffic compared against a table-of-integers reference model.
module tb_branch_predict_unit;

    localparam int unsigned PC_W    = 9;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int PC_MASK = (1 << PC_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    // Reference model state: plain integers per entry.
    bit m_valid [ENTRIES];
    int m_tag   [ENTRIES];
    int m_tgt   [ENTRIES];
    int m_ctr   [ENTRIES];
    int m_nb;
    int m_nm;

    branch_predict_unit_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bp_if ();

    branch_predict_unit #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp_if (bp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_nb = 0;
        m_nm = 0;
    endfunction

    // Drive one cycle of inputs, check every output against the model, then
    // advance the model to its post-edge state.
    task automatic cycle(input int fpc, input bit hlt, input bit rv, input int rpc,
                         input bit rj, input bit rt, input int rtgt,
                         input bit rpt, input int rptgt);
        int  fidx, ftag, ridx, rtag;
        bit  fhit, rhit, ta, e_pt, e_mp;
        int  e_ptgt, e_red, e_np;
        @(negedge clk);
        bp_if.fetch_pc        = PC_W'(fpc);
        bp_if.halt            = hlt;
        bp_if.res_valid       = rv;
        bp_if.res_pc          = PC_W'(rpc);
        bp_if.res_is_jump     = rj;
        bp_if.res_taken       = rt;
        bp_if.res_target      = PC_W'(rtgt);
        bp_if.res_pred_taken  = rpt;
        bp_if.res_pred_target = PC_W'(rptgt);
        #1;
        fidx   = (fpc >> 2) % ENTRIES;
        ftag   = fpc >> 6;
        fhit   = m_valid[fidx] && (m_tag[fidx] == ftag);
        e_pt   = fhit && (m_ctr[fidx] >= 2) && !hlt;
        e_ptgt = fhit ? m_tgt[fidx] : 0;
        ta     = rj || rt;
        e_mp   = rv && ((ta != rpt) || (ta && (rtgt != rptgt)));
        e_red  = !rv ? 0 : (ta ? rtgt : ((rpc + 4) & PC_MASK));
        e_np   = e_mp ? e_red : (hlt ? fpc : (e_pt ? e_ptgt : ((fpc + 4) & PC_MASK)));
        check_eq("pred_taken",    32'(bp_if.pred_taken),    32'(e_pt));
        check_eq("pred_target",   32'(bp_if.pred_target),   e_ptgt);
        check_eq("mispredict",    32'(bp_if.mispredict),    32'(e_mp));
        check_eq("redirect_pc",   32'(bp_if.redirect_pc),   e_red);
        check_eq("next_pc",       32'(bp_if.next_pc),       e_np);
        check_eq("n_branches",    32'(bp_if.n_branches),    m_nb);
        check_eq("n_mispredicts", 32'(bp_if.n_mispredicts), m_nm);
        if (rv) begin
            ridx = (rpc >> 2) % ENTRIES;
            rtag = rpc >> 6;
            rhit = m_valid[ridx] && (m_tag[ridx] == rtag);
            if (!rhit)   m_ctr[ridx] = ta ? 2 : 1;
            else if (rj) m_ctr[ridx] = 3;
            else if (ta) m_ctr[ridx] = (m_ctr[ridx] == 3) ? 3 : m_ctr[ridx] + 1;
            else         m_ctr[ridx] = (m_ctr[ridx] == 0) ? 0 : m_ctr[ridx] - 1;
            m_valid[ridx] = 1'b1;
            m_tag[ridx]   = rtag;
            m_tgt[ridx]   = rtgt;
        end
        if (rv && m_nb < CNT_MAX)   m_nb++;
        if (e_mp && m_nm < CNT_MAX) m_nm++;
    endtask

    task automatic idle(input int fpc, input bit hlt);
        cycle(fpc, hlt, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    // Assert reset while an update is being presented, then check the cleared state.
    task automatic reset_mid_update();
        @(negedge clk);
        bp_if.fetch_pc   = 9'h010;
        bp_if.halt       = 1'b0;
        bp_if.res_valid  = 1'b1;
        bp_if.res_pc     = 9'h010;
        bp_if.res_taken  = 1'b1;
        bp_if.res_target = 9'h040;
        #2 rst_n = 1'b0;
        @(negedge clk);
        bp_if.res_valid = 1'b0;
        #1;
        model_clear();
        check_eq("rst_pred_taken",  32'(bp_if.pred_taken),    0);
        check_eq("rst_pred_target", 32'(bp_if.pred_target),   0);
        check_eq("rst_next_pc",     32'(bp_if.next_pc),       32'h014);
        check_eq("rst_mispredict",  32'(bp_if.mispredict),    0);
        check_eq("rst_redirect",    32'(bp_if.redirect_pc),   0);
        check_eq("rst_n_branches",  32'(bp_if.n_branches),    0);
        check_eq("rst_n_mispred",   32'(bp_if.n_mispredicts), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int pcs [8];
        int tgts [5];
        int rtgt;
        n_checks = 0;
        n_errors = 0;
        pcs  = '{32'h010, 32'h050, 32'h090, 32'h014, 32'h020, 32'h1FC, 32'h100, 32'h0D0};
        tgts = '{32'h040, 32'h100, 32'h0F0, 32'h000, 32'h1FC};
        rst_n                 = 1'b0;
        bp_if.fetch_pc        = 9'h010;
        bp_if.halt            = 1'b0;
        bp_if.res_valid       = 1'b0;
        bp_if.res_pc          = '0;
        bp_if.res_is_jump     = 1'b0;
        bp_if.res_taken       = 1'b0;
        bp_if.res_target      = '0;
        bp_if.res_pred_taken  = 1'b0;
        bp_if.res_pred_target = '0;
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        check_eq("init_pred_taken", 32'(bp_if.pred_taken),    0);
        check_eq("init_next_pc",    32'(bp_if.next_pc),       32'h014);
        check_eq("init_n_branches", 32'(bp_if.n_branches),    0);
        check_eq("init_n_mispred",  32'(bp_if.n_mispredicts), 0);
        rst_n = 1'b1;

        // Cold taken branch, then it predicts taken at fetch.
        cycle(32'h010, 0, 1, 32'h010, 0, 1, 32'h040, 0, 0);
        check_eq("dir_cold_mp",  32'(bp_if.mispredict),  1);
        check_eq("dir_cold_red", 32'(bp_if.redirect_pc), 32'h040);
        idle(32'h010, 0);
        check_eq("dir_hit_pt",   32'(bp_if.pred_taken),  1);
        check_eq("dir_hit_ptgt", 32'(bp_if.pred_target), 32'h040);

        // Three not-taken resolutions: 10 -> 01 -> 00 -> 00.
        cycle(32'h000, 0, 1, 32'h010, 0, 0, 32'h040, 1, 32'h040);
        check_eq("dir_nt1_mp",  32'(bp_if.mispredict),  1);
        check_eq("dir_nt1_red", 32'(bp_if.redirect_pc), 32'h014);
        cycle(32'h000, 0, 1, 32'h010, 0, 0, 32'h040, 0, 32'h040);
        check_eq("dir_nt2_mp", 32'(bp_if.mispredict), 0);
        cycle(32'h000, 0, 1, 32'h010, 0, 0, 32'h040, 0, 32'h040);
        check_eq("dir_nt3_mp", 32'(bp_if.mispredict), 0);
        // One taken step from a saturated 00 must land on 01 (still not-taken).
        cycle(32'h000, 0, 1, 32'h010, 0, 1, 32'h040, 0, 0);
        idle(32'h010, 0);
        check_eq("dir_sat_pt", 32'(bp_if.pred_taken), 0);

        // jalr with wrong carried target.
        cycle(32'h000, 0, 1, 32'h020, 1, 0, 32'h100, 1, 32'h0F0);
        check_eq("dir_jalr_mp",  32'(bp_if.mispredict),  1);
        check_eq("dir_jalr_red", 32'(bp_if.redirect_pc), 32'h100);
        idle(32'h020, 0);
        check_eq("dir_jalr_pt", 32'(bp_if.pred_taken), 1);

        // Aliasing: 0x050 shares the index of 0x010 with a different tag.
        cycle(32'h000, 0, 1, 32'h050, 0, 0, 32'h0A8, 0, 0);
        idle(32'h010, 0);
        check_eq("dir_alias_ptgt", 32'(bp_if.pred_target), 0);
        idle(32'h050, 0);
        check_eq("dir_alias_hit", 32'(bp_if.pred_target), 32'h0A8);

        // PC wrap and halt behaviour.
        idle(32'h1FC, 0);
        check_eq("dir_wrap_np", 32'(bp_if.next_pc), 0);
        idle(32'h020, 1);
        check_eq("dir_halt_np", 32'(bp_if.next_pc),    32'h020);
        check_eq("dir_halt_pt", 32'(bp_if.pred_taken), 0);
        cycle(32'h020, 1, 1, 32'h030, 0, 1, 32'h0C0, 0, 0);
        check_eq("dir_halt_mp_np", 32'(bp_if.next_pc), 32'h0C0);
        idle(32'h020, 0);

        reset_mid_update();
        idle(32'h010, 0);
        cycle(32'h010, 0, 1, 32'h010, 0, 1, 32'h040, 0, 0);
        idle(32'h010, 0);
        check_eq("post_rst_pt", 32'(bp_if.pred_taken), 1);

        // Drive the stat counters into saturation.
        for (int i = 0; i < CNT_MAX + 5; i++)
            cycle(32'h080, 0, 1, 32'h080, 0, 1, 32'h040, 0, 0);
        idle(32'h000, 0);
        check_eq("sat_n_mispred", 32'(bp_if.n_mispredicts), CNT_MAX);
        check_eq("sat_n_branches", 32'(bp_if.n_branches),   CNT_MAX);

        reset_mid_update();
        for (int i = 0; i < 200; i++) begin
            rtgt = tgts[$urandom_range(0, 4)];
            cycle(pcs[$urandom_range(0, 7)], ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1), pcs[$urandom_range(0, 7)],
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 1), rtgt,
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 1) == 1) ? rtgt : tgts[$urandom_range(0, 4)]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
